// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// width limit and the quotient pattern reported on divide-by-zero.
package div_pkg;

  localparam int DIV_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // All-ones in the low 'width' bits; the caller slices what it needs.
  function automatic logic [DIV_MAX_WIDTH-1:0] dbz_quotient(input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return mask[DIV_MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the arithmetic datapaths.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/trial_subtractor.sv
// N-bit ripple subtractor a - b built as a + ~b + 1 from full adder cells;
// borrow is the inverted final carry.
module trial_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done
// handshake. Define DIV_SIGNED_EN for two's complement operands.
//
// Handshake: start is sampled only in IDLE (busy=0); operands are captured on
// that edge. busy covers RUN and DONE; done is a one-cycle registered pulse
// during which quotient/remainder/div_by_zero are valid, and they hold until
// the next accepted operation completes.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_MAX_WIDTH-1:0] DBZ_PATTERN = dbz_quotient(WIDTH);

  div_state_t state_q, state_d;

  // Partial remainder stays below the divisor, so its top bit is always zero
  // and only WIDTH bits are kept.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_borrow, trial_fits;
  logic [WIDTH-1:0] r_next, q_next, r_fin, q_fin;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             accept, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);

  assign trial_a = {r_q, q_q[WIDTH-1]};
  assign trial_b = {1'b0, d_q};

  trial_subtractor #(
    .N (WIDTH + 1)
  ) u_trial (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // A successful trial always lands below 2^WIDTH; requiring the top bit to
  // be clear as well keeps the stored remainder in range by construction.
  assign trial_fits = ~trial_borrow & ~trial_diff[WIDTH];
  assign r_next     = trial_fits ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
  assign q_next     = {q_q[WIDTH-2:0], trial_fits};

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_fin   = neg_q_q ? -q_next : q_next;
  assign r_fin   = neg_r_q ? -r_next : r_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = q_next;
  assign r_fin   = r_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        q_q   <= dvd_mag;
        d_q   <= dvs_mag;
        r_q   <= '0;
        cnt_q <= CW'(WIDTH - 1);
        if (divisor == '0) begin
          quotient    <= DBZ_PATTERN[WIDTH-1:0];
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
      end else if (state_q == ST_RUN) begin
        r_q   <= r_next;
        q_q   <= q_next;
        cnt_q <= cnt_q - 1'b1;
        if (last) begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the array multiplier datapath.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake so a controller can reuse it between multiplier operations.
- Trial subtraction is a ripple subtractor built from the codebase's adder cells.

Parameters:
WIDTH, 8, operand / quotient / remainder width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
div_by_zero  output  1  registered flag; set with done when divisor was 0

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset, asserted at any time including mid-operation:
  - state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers cleared.
  - Operation in flight is abandoned; no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding from the package).
- IDLE, start=1 at edge k:
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits) and set cnt=WIDTH-1.
  - If divisor==0: go directly to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1; done high in the cycle after edge k.
  - Else: go to RUN.
- RUN, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed WIDTH+1 bits wide.
  - If borrow=0: R=T and shift 1 into Q LSB. Else: R unchanged-shifted ({R[WIDTH-1:0],Q[MSB]}) and shift 0 into Q LSB.
  - cnt decrements each edge.
  - On the edge where cnt==0: register quotient=final Q, remainder=final R[WIDTH-1:0], div_by_zero=0; go to DONE.
- Latency: done is high in the cycle after the WIDTH-th edge following the start edge. For WIDTH=8 that is 8 edges after acceptance.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
- start while busy=1 (RUN or DONE) is ignored and not queued. Operand changes while busy have no effect.
- quotient, remainder and div_by_zero hold their values until the next accepted start's result is registered. They are not cleared on start.
- start held high continuously: back-to-back operations every WIDTH+2 cycles (IDLE cycle included).
- busy is combinational from state; done is registered.

Optional Feature:
DIV_SIGNED_EN
- Defined:
  - Operands are two's complement.
  - Magnitudes are divided by the same unsigned core.
  - Quotient is negated if the operand signs differ, truncating toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case -2^(WIDTH-1) / -1 gives quotient=-2^(WIDTH-1), remainder=0, no flag.
  - Divide-by-zero gives quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Latency unchanged: sign fix-up is applied when registering outputs.
- Undefined: unsigned only, no sign logic synthesized.

Decomposition:
- Package div_pkg:
  - State typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Constant DIV_MAX_WIDTH=32.
  - Divide-by-zero quotient pattern helper.
- Sub-module trial_subtractor:
  - (WIDTH+1)-bit ripple subtractor, a - b, outputs diff and borrow.
  - Built from the existing full/half adder cells with b inverted and carry-in 1.
  - borrow = ~carry_out.
- Top holds FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start one cycle -> done exactly 8 edges after accept; quotient=14, remainder=2, div_by_zero=0; busy high for 9 cycles.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- divisor=0, dividend=77 -> done in the cycle after accept; quotient=8'hFF, remainder=77, div_by_zero=1. Next normal op 20/4 clears the flag: quotient=5, remainder=0.
- start pulsed with 50/3 during RUN of 200/13 -> second request ignored; only quotient=15, remainder=5 produced; one done pulse.
- rst asserted asynchronously mid-RUN (cycle 4 of 8) -> outputs immediately 0, state IDLE, no done. A fresh 9/2 afterwards gives quotient=4, remainder=1.
- DIV_SIGNED_EN defined: -100/7 -> quotient=-14, remainder=-2. -128/-1 -> quotient=-128, remainder=0. 100/-7 -> quotient=-14, remainder=2.
